// File: rtl/cdc_pkg.sv
// =====================================================================
// Package  : cdc_pkg
// Brief    : Shared FSM encoding, default parameters and round-robin
//            grant helper for the clka-side CDC event arbiter.
// Revision : 1.0
// =====================================================================
`default_nettype none

package cdc_pkg;

   localparam int c_n_req       = 4;
   localparam int c_data_w      = 8;
   localparam int c_sync_stages = 2;
   localparam int c_timeout_w   = 10;
   localparam int c_max_req     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } cdc_state_e;

   // First set bit of req searching ptr+1, ptr+2, ... modulo n.
   function automatic logic rr_grant(
      input  logic [c_max_req-1:0] req,
      input  int                   n,
      input  int                   ptr,
      output int                   idx
   );
      logic                 valid;
      int                   j;
      logic [c_max_req-1:0] sh;
      valid = 1'b0;
      idx   = 0;
      for (int k = 1; k <= c_max_req; k++) begin
         if (k <= n) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            sh = req >> j;
            if (!valid && sh[0]) begin
               valid = 1'b1;
               idx   = j;
            end
         end
      end
      return valid;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_sync_bit.sv
// =====================================================================
// Module   : cdc_sync_bit
// Brief    : STAGES-deep single-bit synchronizer with async reset.
// Revision : 1.0
// =====================================================================
`default_nettype none

module cdc_sync_bit
   import cdc_pkg::*;
#(
   parameter int STAGES = c_sync_stages
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[STAGES-2:0], d};
   end

   assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cdc_event_arbiter.sv
// =====================================================================
// Module   : cdc_event_arbiter
// Brief    : Latches per-source event pulses and shares one 4-phase
//            req/ack channel round-robin. CDC_TIMEOUT_EN adds ack watchdog.
// Revision : 1.0
// =====================================================================
`default_nettype none

module cdc_event_arbiter
   import cdc_pkg::*;
#(
   parameter int N_REQ       = c_n_req,
   parameter int DATA_W      = c_data_w,
   parameter int SYNC_STAGES = c_sync_stages,
   parameter int TIMEOUT_W   = c_timeout_w
) (
   input  logic                      clka,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          evt_i,
   input  logic [N_REQ*DATA_W-1:0]   evt_data_i,
   output logic                      cdc_req_o,
   output logic [$clog2(N_REQ)-1:0]  cdc_id_o,
   output logic [DATA_W-1:0]         cdc_data_o,
   input  logic                      cdc_ack_i,
   output logic                      busy_o,
   output logic [N_REQ-1:0]          pend_o,
   output logic [N_REQ-1:0]          drop_o,
   output logic                      err_o
);

   localparam int c_id_w = $clog2(N_REQ);

   cdc_state_e            r_state;
   logic [c_id_w-1:0]     r_ptr;
   logic                  r_req;
   logic [c_id_w-1:0]     r_id;
   logic [DATA_W-1:0]     r_data;
   logic [N_REQ-1:0]      r_pend;
   logic [N_REQ-1:0]      r_drop;
   logic [DATA_W-1:0]     r_slot [N_REQ];

   logic                  w_ack_s;
   logic                  w_issue;
   logic                  w_gnt_valid;
   int                    w_gnt_int;
   logic [c_id_w-1:0]     w_gnt_id;
   logic [c_max_req-1:0]  w_req_ext;
   logic [N_REQ-1:0]      w_clr;

   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (clka),
      .rst_n (rst_n),
      .d     (cdc_ack_i),
      .q     (w_ack_s)
   );

   always_comb begin
      w_req_ext              = '0;
      w_req_ext[N_REQ-1:0]   = r_pend;
      w_gnt_int              = 0;
      w_gnt_valid            = rr_grant(w_req_ext, N_REQ, int'(r_ptr), w_gnt_int);
      w_gnt_id               = c_id_w'(w_gnt_int);
      // A lingering ack from the previous transfer blocks a new request.
      w_issue                = (r_state == IDLE) && w_gnt_valid && !w_ack_s;
      w_clr                  = '0;
      if (w_issue) w_clr[w_gnt_id] = 1'b1;
   end

   // An event arriving on its own grant edge refills the slot just freed.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_drop <= '0;
         for (int i = 0; i < N_REQ; i++) r_slot[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            r_drop[i] <= evt_i[i] && r_pend[i] && !w_clr[i];
            if (evt_i[i] && (!r_pend[i] || w_clr[i])) begin
               r_pend[i] <= 1'b1;
               r_slot[i] <= evt_data_i[i*DATA_W +: DATA_W];
            end else if (w_clr[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= c_id_w'(N_REQ - 1);
         r_req   <= 1'b0;
         r_id    <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_id    <= w_gnt_id;
                  r_data  <= r_slot[w_gnt_id];
                  r_req   <= 1'b1;
                  r_ptr   <= w_gnt_id;
                  r_state <= REQ;
               end
            end
            REQ: begin
               if (w_ack_s) begin
                  r_req   <= 1'b0;
                  r_state <= REL;
               end
            end
            REL: begin
               if (!w_ack_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef CDC_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_tmo;
   logic                 r_err;

   // Counter restarts on entry to REQ and to REL, then saturates.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else if (w_issue || (r_state == REQ && w_ack_s)) begin
         r_tmo <= '0;
      end else if (r_state != IDLE && r_tmo != '1) begin
         r_tmo <= r_tmo + 1'b1;
         if (r_tmo == ~TIMEOUT_W'(1)) r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign err_o = |{TIMEOUT_W{1'b0}};
`endif

   assign cdc_req_o  = r_req;
   assign cdc_id_o   = r_id;
   assign cdc_data_o = r_data;
   assign busy_o     = (r_state != IDLE);
   assign pend_o     = r_pend;
   assign drop_o     = r_drop;

endmodule

`default_nettype wire
